// File: rtl/contador_decoder.sv
// contador_decoder: observes the output stream of an up/down/load counter and
// reconstructs, step by step, the command that produced each new sample.
// Each reconstructed step is reported as a registered one-cycle event, and the
// block also tracks the current direction, the run length in that direction,
// and saturating per-event-class statistics.
module contador_decoder #(
  parameter int WIDTH = 8,
  parameter int RUN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             clear_stats,
  output logic             evt_valid,
  output logic [2:0]       evt_code,
  output logic [WIDTH-1:0] evt_value,
  output logic             dir_up,
  output logic             dir_change,
  output logic [RUN_W-1:0] run_len,
  output logic [CNT_W-1:0] up_cnt,
  output logic [CNT_W-1:0] down_cnt,
  output logic [CNT_W-1:0] jump_cnt
);

  localparam logic [2:0] EVT_HOLD    = 3'd0;
  localparam logic [2:0] EVT_UP      = 3'd1;
  localparam logic [2:0] EVT_DOWN    = 3'd2;
  localparam logic [2:0] EVT_JUMP    = 3'd3;
  localparam logic [2:0] EVT_WRAP_UP = 3'd4;
  localparam logic [2:0] EVT_WRAP_DN = 3'd5;

  // IDLE has no reference sample yet; PRIMED can decode every new sample.
  typedef enum logic {IDLE, PRIMED} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             evt_valid_q, evt_valid_d;
  logic [2:0]       evt_code_q, evt_code_d;
  logic [WIDTH-1:0] evt_value_q, evt_value_d;
  logic             dir_up_q, dir_up_d;
  logic             dir_change_q, dir_change_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] up_cnt_q, up_cnt_d;
  logic [CNT_W-1:0] down_cnt_q, down_cnt_d;
  logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;

  logic [WIDTH-1:0] diff;
  logic [2:0]       dec_code;
  logic             fire;

  // State register for the capture/decode FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The first valid sample after reset only primes the reference; nothing but reset leaves PRIMED.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && sample_valid) begin
      state_d = PRIMED;
    end
  end

  // Classify the step from the previous sample; the two-element wrap cases need prev at the extremes.
  always_comb begin
    diff = sample_in - prev_q;
    fire = sample_valid && (state_q == PRIMED);
    if (diff == '0) begin
      dec_code = EVT_HOLD;
    end else if (diff == WIDTH'(1)) begin
      dec_code = (prev_q == '1) ? EVT_WRAP_UP : EVT_UP;
    end else if (diff == '1) begin
      dec_code = (prev_q == '0) ? EVT_WRAP_DN : EVT_DOWN;
    end else begin
      dec_code = EVT_JUMP;
    end
  end

  // Event, direction, run-length and statistics updates driven by a decoded step.
  always_comb begin
    prev_d       = prev_q;
    evt_valid_d  = 1'b0;
    dir_change_d = 1'b0;
    evt_code_d   = evt_code_q;
    evt_value_d  = evt_value_q;
    dir_up_d     = dir_up_q;
    run_len_d    = run_len_q;
    up_cnt_d     = up_cnt_q;
    down_cnt_d   = down_cnt_q;
    jump_cnt_d   = jump_cnt_q;

    if (sample_valid) begin
      prev_d = sample_in;
    end

    if (fire) begin
      evt_valid_d = 1'b1;
      evt_code_d  = dec_code;
      evt_value_d = sample_in;
      case (dec_code)
        EVT_UP, EVT_WRAP_UP: begin
          if (dir_up_q || run_len_q == '0) begin
            run_len_d = (run_len_q == '1) ? run_len_q : run_len_q + RUN_W'(1);
          end else begin
            dir_change_d = 1'b1;
            run_len_d    = RUN_W'(1);
          end
          dir_up_d = 1'b1;
          up_cnt_d = (up_cnt_q == '1) ? up_cnt_q : up_cnt_q + CNT_W'(1);
        end
        EVT_DOWN, EVT_WRAP_DN: begin
          if (!dir_up_q || run_len_q == '0) begin
            run_len_d = (run_len_q == '1) ? run_len_q : run_len_q + RUN_W'(1);
          end else begin
            dir_change_d = 1'b1;
            run_len_d    = RUN_W'(1);
          end
          dir_up_d   = 1'b0;
          down_cnt_d = (down_cnt_q == '1) ? down_cnt_q : down_cnt_q + CNT_W'(1);
        end
        EVT_JUMP: begin
          run_len_d  = '0;
          jump_cnt_d = (jump_cnt_q == '1) ? jump_cnt_q : jump_cnt_q + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end

    if (clear_stats) begin
      up_cnt_d   = '0;
      down_cnt_d = '0;
      jump_cnt_d = '0;
    end
  end

  // Datapath registers; reset drops any pending event and restores the idle view.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q       <= '0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= '0;
      evt_value_q  <= '0;
      dir_up_q     <= 1'b1;
      dir_change_q <= 1'b0;
      run_len_q    <= '0;
      up_cnt_q     <= '0;
      down_cnt_q   <= '0;
      jump_cnt_q   <= '0;
    end else begin
      prev_q       <= prev_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_value_q  <= evt_value_d;
      dir_up_q     <= dir_up_d;
      dir_change_q <= dir_change_d;
      run_len_q    <= run_len_d;
      up_cnt_q     <= up_cnt_d;
      down_cnt_q   <= down_cnt_d;
      jump_cnt_q   <= jump_cnt_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    evt_valid  = evt_valid_q;
    evt_code   = evt_code_q;
    evt_value  = evt_value_q;
    dir_up     = dir_up_q;
    dir_change = dir_change_q;
    run_len    = run_len_q;
    up_cnt     = up_cnt_q;
    down_cnt   = down_cnt_q;
    jump_cnt   = jump_cnt_q;
  end

endmodule

// File: tb/tb_contador_decoder.sv
// tb_contador_decoder: table-driven bench for contador_decoder. Each record
// holds the inputs for one cycle and the outputs expected one clock later.
module tb_contador_decoder;

  logic        clock;
  logic        reset;
  logic [7:0]  sample_in;
  logic        sample_valid;
  logic        clear_stats;
  logic        evt_valid;
  logic [2:0]  evt_code;
  logic [7:0]  evt_value;
  logic        dir_up;
  logic        dir_change;
  logic [7:0]  run_len;
  logic [15:0] up_cnt;
  logic [15:0] down_cnt;
  logic [15:0] jump_cnt;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  smp;
    logic        clr;
    logic        exp_evt;
    logic [2:0]  exp_code;
    logic        exp_dir;
    logic        exp_dc;
    logic [7:0]  exp_run;
    logic [15:0] exp_up;
    logic [15:0] exp_dn;
    logic [15:0] exp_jmp;
  } vec_t;

  vec_t vecs[$];
  vec_t score_q[$];
  int   vectors_applied = 0;
  int   miscompares = 0;

  contador_decoder #(.WIDTH(8), .RUN_W(8), .CNT_W(16)) dut (
    .clock(clock),
    .reset(reset),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .clear_stats(clear_stats),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .evt_value(evt_value),
    .dir_up(dir_up),
    .dir_change(dir_change),
    .run_len(run_len),
    .up_cnt(up_cnt),
    .down_cnt(down_cnt),
    .jump_cnt(jump_cnt)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic vld, input logic [7:0] smp,
                              input logic clr, input logic evt, input logic [2:0] code,
                              input logic dir, input logic dc, input logic [7:0] run,
                              input logic [15:0] up, input logic [15:0] dn,
                              input logic [15:0] jmp);
    vec_t v;
    v.rst = rst; v.vld = vld; v.smp = smp; v.clr = clr;
    v.exp_evt = evt; v.exp_code = code; v.exp_dir = dir; v.exp_dc = dc;
    v.exp_run = run; v.exp_up = up; v.exp_dn = dn; v.exp_jmp = jmp;
    return v;
  endfunction

  function automatic vec_t rst_vec(input logic vld, input logic [7:0] smp);
    return mk(1'b1, vld, smp, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd0, 16'd0, 16'd0, 16'd0);
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp_v);
    if (act != exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp_v);
    end
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (score_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty vec %0d: got 0 entries expected 1", idx);
      return;
    end
    e = score_q.pop_front();
    chk("evt_valid", idx, int'(evt_valid), int'(e.exp_evt));
    if (e.exp_evt) begin
      chk("evt_code", idx, int'(evt_code), int'(e.exp_code));
      chk("evt_value", idx, int'(evt_value), int'(e.smp));
    end
    chk("dir_up", idx, int'(dir_up), int'(e.exp_dir));
    chk("dir_change", idx, int'(dir_change), int'(e.exp_dc));
    chk("run_len", idx, int'(run_len), int'(e.exp_run));
    chk("up_cnt", idx, int'(up_cnt), int'(e.exp_up));
    chk("down_cnt", idx, int'(down_cnt), int'(e.exp_dn));
    chk("jump_cnt", idx, int'(jump_cnt), int'(e.exp_jmp));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    reset        = v.rst;
    sample_valid = v.vld;
    sample_in    = v.smp;
    clear_stats  = v.clr;
    score_q.push_back(v);
    vectors_applied++;
    @(posedge clock);
    #1;
    checkOutput(idx);
  endtask

  // Directed table, then a long UP stream for the saturation corners.
  initial begin
    vec_t v;
    int   step;
    reset = 1'b1; sample_valid = 1'b0; sample_in = '0; clear_stats = 1'b0;

    // Consecutive UP steps; the priming sample yields no event.
    vecs.push_back(rst_vec(1'b0, 8'd0));
    vecs.push_back(mk(0,1,8'd9,  0, 0,3'd0,1,0,8'd0, 16'd0,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd10, 0, 1,3'd1,1,0,8'd1, 16'd1,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd11, 0, 1,3'd1,1,0,8'd2, 16'd2,16'd0,16'd0));
    // Upward wrap through 255 -> 0.
    vecs.push_back(rst_vec(1'b0, 8'd0));
    vecs.push_back(mk(0,1,8'd254,0, 0,3'd0,1,0,8'd0, 16'd0,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd255,0, 1,3'd1,1,0,8'd1, 16'd1,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd0,  0, 1,3'd4,1,0,8'd2, 16'd2,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd1,  0, 1,3'd1,1,0,8'd3, 16'd3,16'd0,16'd0));
    // Down run followed by a reversal.
    vecs.push_back(rst_vec(1'b0, 8'd0));
    vecs.push_back(mk(0,1,8'd5,  0, 0,3'd0,1,0,8'd0, 16'd0,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd4,  0, 1,3'd2,0,0,8'd1, 16'd0,16'd1,16'd0));
    vecs.push_back(mk(0,1,8'd3,  0, 1,3'd2,0,0,8'd2, 16'd0,16'd2,16'd0));
    vecs.push_back(mk(0,1,8'd4,  0, 1,3'd1,1,1,8'd1, 16'd1,16'd2,16'd0));
    // Downward wrap, an idle gap, then HOLD.
    vecs.push_back(rst_vec(1'b0, 8'd0));
    vecs.push_back(mk(0,1,8'd1,  0, 0,3'd0,1,0,8'd0, 16'd0,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd0,  0, 1,3'd2,0,0,8'd1, 16'd0,16'd1,16'd0));
    vecs.push_back(mk(0,1,8'd255,0, 1,3'd5,0,0,8'd2, 16'd0,16'd2,16'd0));
    vecs.push_back(mk(0,0,8'd77, 0, 0,3'd0,0,0,8'd2, 16'd0,16'd2,16'd0));
    vecs.push_back(mk(0,1,8'd255,0, 1,3'd0,0,0,8'd2, 16'd0,16'd2,16'd0));
    // Load jumps clear the run so the next step starts fresh either way.
    vecs.push_back(rst_vec(1'b0, 8'd0));
    vecs.push_back(mk(0,1,8'd20, 0, 0,3'd0,1,0,8'd0, 16'd0,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd9,  0, 1,3'd3,1,0,8'd0, 16'd0,16'd0,16'd1));
    vecs.push_back(mk(0,1,8'd10, 0, 1,3'd1,1,0,8'd1, 16'd1,16'd0,16'd1));
    vecs.push_back(mk(0,1,8'd30, 0, 1,3'd3,1,0,8'd0, 16'd1,16'd0,16'd2));
    vecs.push_back(mk(0,1,8'd29, 0, 1,3'd2,0,0,8'd1, 16'd1,16'd1,16'd2));
    // Reset while primed with a pending sample, then stats clear interactions.
    vecs.push_back(rst_vec(1'b0, 8'd0));
    vecs.push_back(mk(0,1,8'd3,  0, 0,3'd0,1,0,8'd0, 16'd0,16'd0,16'd0));
    vecs.push_back(rst_vec(1'b1, 8'd99));
    vecs.push_back(mk(0,1,8'd4,  0, 0,3'd0,1,0,8'd0, 16'd0,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd5,  0, 1,3'd1,1,0,8'd1, 16'd1,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd6,  1, 1,3'd1,1,0,8'd2, 16'd0,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd7,  0, 1,3'd1,1,0,8'd3, 16'd1,16'd0,16'd0));
    vecs.push_back(mk(0,0,8'd0,  1, 0,3'd0,1,0,8'd3, 16'd0,16'd0,16'd0));
    vecs.push_back(mk(0,1,8'd8,  0, 1,3'd1,1,0,8'd4, 16'd1,16'd0,16'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Long UP stream: run_len saturates at 255, up_cnt saturates at 65535.
    step = vecs.size();
    applyStimulus(rst_vec(1'b0, 8'd0), step++);
    applyStimulus(mk(0,1,8'd0,0, 0,3'd0,1,0,8'd0, 16'd0,16'd0,16'd0), step++);
    for (int i = 1; i <= 65600; i++) begin
      v = mk(1'b0, 1'b1, 8'(i % 256), 1'b0, 1'b1,
             ((i % 256) == 0) ? 3'd4 : 3'd1, 1'b1, 1'b0,
             (i > 255) ? 8'd255 : 8'(i),
             (i > 65535) ? 16'd65535 : 16'(i), 16'd0, 16'd0);
      applyStimulus(v, step++);
    end

    if (score_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", score_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
